// File: rtl/regfile_debug_port_pkg.sv
// Shared definitions for the register-file debug access engine.
package regfile_debug_port_pkg;

    localparam int DEFAULT_WIDTH      = 32;
    localparam int DEFAULT_ADDR_WIDTH = 5;

    localparam logic [1:0] OP_READ  = 2'd0;
    localparam logic [1:0] OP_WRITE = 2'd1;
    localparam logic [1:0] OP_DUMP  = 2'd2;
    localparam logic [1:0] OP_NOP   = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2,
        RESP = 2'd3
    } dbgState_t;

endpackage

// File: rtl/regfile_debug_port.sv
// Debug initiator on the register-file read/write ports: single read,
// single write, or a dump of every register, with read data returned over
// a valid/ready response channel.
//
// state | meaning
// IDLE  | ready for a host command
// WR    | one-cycle write strobe to the regfile (suppressed for $zero)
// RD    | present address, capture regfile read data into response regs
// RESP  | response offered, held until rspReady
module regfile_debug_port
    import regfile_debug_port_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmdValid,
    output logic                  cmdReady,
    input  logic [1:0]            cmdOp,
    input  logic [ADDR_WIDTH-1:0] cmdAddr,
    input  logic [WIDTH-1:0]      cmdData,
    output logic                  rspValid,
    input  logic                  rspReady,
    output logic [ADDR_WIDTH-1:0] rspAddr,
    output logic [WIDTH-1:0]      rspData,
    output logic                  rspLast,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] readAddr,
    input  logic [WIDTH-1:0]      readData,
    output logic                  regWrite,
    output logic [ADDR_WIDTH-1:0] writeAddr,
    output logic [WIDTH-1:0]      writeData
);

    localparam logic [ADDR_WIDTH-1:0] TOP_ADDR = '1;

    dbgState_t             state;
    dbgState_t             nextState;
    logic                  dumpFlag;
    logic [ADDR_WIDTH-1:0] addrQ;
    logic [WIDTH-1:0]      dataQ;

    // State register; reset abandons any command in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next state and port outputs; reset masks every strobe and handshake.
    always_comb begin
        nextState = state;
        cmdReady  = 1'b0;
        rspValid  = 1'b0;
        regWrite  = 1'b0;
        readAddr  = '0;
        busy      = (state != IDLE);
        writeAddr = addrQ;
        writeData = dataQ;
        case (state)
            IDLE: begin
                cmdReady = !reset;
                if (cmdValid) begin
                    case (cmdOp)
                        OP_READ:  nextState = RD;
                        OP_WRITE: nextState = WR;
                        OP_DUMP:  nextState = RD;
                        default:  nextState = IDLE;
                    endcase
                end
            end
            WR: begin
                regWrite  = !reset && (addrQ != '0);
                nextState = IDLE;
            end
            RD: begin
                readAddr  = addrQ;
                nextState = RESP;
            end
            RESP: begin
                rspValid = !reset;
                if (rspReady) begin
                    nextState = (dumpFlag && !rspLast) ? RD : IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    // Command latch, dump address counter and response capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            dumpFlag <= 1'b0;
            addrQ    <= '0;
            dataQ    <= '0;
            rspAddr  <= '0;
            rspData  <= '0;
            rspLast  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmdValid) begin
                        dumpFlag <= (cmdOp == OP_DUMP);
                        addrQ    <= (cmdOp == OP_DUMP) ? '0 : cmdAddr;
                        dataQ    <= cmdData;
                    end
                end
                RD: begin
                    rspAddr <= addrQ;
                    rspData <= readData;
                    rspLast <= !dumpFlag || (addrQ == TOP_ADDR);
                end
                RESP: begin
                    // Dump stops on rspLast at the top register, so the
                    // counter never needs to wrap.
                    if (rspReady && dumpFlag && !rspLast) begin
                        addrQ <= addrQ + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/regfile_debug_port.md
# regfile_debug_port

Debug access engine that acts as the initiator on the register file's read/write port pair. It accepts host commands over a valid/ready channel: single read, single write, or full dump of all registers. It drives `readAddr`, `writeAddr`, `writeData` and `regWrite` into the register file and returns read data over a valid/ready response channel. It sits beside the multicycle datapath. `busy` tells the top level to stall the core and switch the register-file ports to this block.

## Interface
- `WIDTH`, 32, register data width
- `ADDR_WIDTH`, 5, register address width; register count is 2**ADDR_WIDTH
- `clk`  in  1  sole clock; all state changes on posedge
- `reset`  in  1  synchronous, active-high
- `cmdValid`  in  1  command offered
- `cmdReady`  out  1  command accepted when both high
- `cmdOp`  in  2  0=READ, 1=WRITE, 2=DUMP, 3=NOP
- `cmdAddr`  in  ADDR_WIDTH  target register (READ/WRITE)
- `cmdData`  in  WIDTH  write data (WRITE)
- `rspValid`  out  1  response offered
- `rspReady`  in  1  response consumed when both high
- `rspAddr`  out  ADDR_WIDTH  register the data came from
- `rspData`  out  WIDTH  captured register value
- `rspLast`  out  1  final response of the command
- `busy`  out  1  high whenever state != IDLE
- `readAddr`  out  ADDR_WIDTH  to regfile read port
- `readData`  in  WIDTH  from regfile; combinational w.r.t. `readAddr`
- `regWrite`  out  1  regfile write enable
- `writeAddr`  out  ADDR_WIDTH  to regfile
- `writeData`  out  WIDTH  to regfile

## Operation
- The FSM has four states: IDLE, WR, RD, RESP.
- IDLE
  - `cmdReady`=1.
  - On handshake, latch op, addr and data.
  - READ → RD. WRITE → WR. DUMP → RD with the dump flag set and addr=0. NOP → stay in IDLE; no response.
- WR
  - Drive `regWrite`=1 with the latched `writeAddr`/`writeData` for exactly one cycle, then → IDLE.
  - A write to address 0 still spends the WR cycle, but `regWrite` stays 0, so $zero is preserved.
  - WRITE produces no response.
- RD
  - `readAddr`=latched addr.
  - Capture `readData` into `rspData` and the addr into `rspAddr`.
  - `rspLast` = !dump OR addr == 2**ADDR_WIDTH-1.
  - → RESP.
- RESP
  - `rspValid`=1.
  - `rspAddr`, `rspData` and `rspLast` are held stable until `rspReady`.
  - On handshake: if dump and not last, addr+1 → RD; otherwise → IDLE.
- The address counter is ADDR_WIDTH bits and never wraps. The dump ends at the top register via the `rspLast` compare; there is no overflow compare.
- Default outputs:
  - `readAddr`=0 outside RD.
  - `regWrite`=0 outside WR.
  - `writeAddr`/`writeData` hold the latched values.
- Reset values:
  - State IDLE.
  - `cmdReady`=0 while `reset`=1.
  - `rspValid`=0, `rspData`=0, `rspAddr`=0, `rspLast`=0.
  - `regWrite`=0, `busy`=0, all address/data outputs 0.
- Reset mid-operation aborts immediately:
  - A pending response is dropped.
  - No `regWrite` is asserted in any cycle where `reset`=1.
  - The dump does not resume.

## Timing
- Command accepted at edge N (IDLE).
- READ: RD during cycle N+1; `rspValid` from cycle N+2; earliest `cmdReady` is the cycle after the response handshake.
- WRITE: `regWrite` high during cycle N+1, so the regfile updates at edge N+2. `cmdReady` returns in cycle N+2; a READ of the same address accepted then returns the new value.
- DUMP with `rspReady` tied high: 2 cycles per register, so 64 cycles for 32 registers. `rspValid` asserts on alternate cycles.
- Back-pressure: each cycle `rspReady`=0 extends RESP by one cycle, with no data change.
- `cmdReady` is combinational from state only. It never depends on `cmdValid`.

## Structure
- A shared package holds:
  - op encodings `OP_READ`/`OP_WRITE`/`OP_DUMP`/`OP_NOP`;
  - state enum `IDLE`/`WR`/`RD`/`RESP`;
  - `ADDR_WIDTH`/`WIDTH` defaults.
- No sub-module: a single FSM plus address counter and response registers. The regfile is instantiated only in the bench and the top level.

## Test plan
- Reset, then WRITE addr 8 data 32'hDEADBEEF, then READ 8. `regWrite` is high for exactly one cycle. Response: `rspAddr`=8, `rspData`=32'hDEADBEEF, `rspLast`=1, arriving 2 cycles after acceptance.
- WRITE addr 0 data 32'h12345678, then READ 0. `regWrite` never asserts; `rspData`=0.
- Preload reg i = i*32'h01010101 for all i, DUMP with `rspReady`=1:
  - 32 responses, addr 0..31 in order, values match;
  - `rspLast` only on addr 31;
  - completes in 64 cycles.
- READ with `rspReady` low for 5 cycles:
  - `rspValid` stays high;
  - `rspData` and `rspAddr` stay stable;
  - `cmdReady`=0 throughout;
  - single handshake on release.
- Assert `reset` during a DUMP at addr 13:
  - next cycle `rspValid`=0, `busy`=0;
  - `cmdReady`=1 after `reset` drops;
  - no further responses.
- NOP then READ back-to-back: NOP yields no response and `busy` stays 0. The READ is accepted on the next cycle.
